// File: rtl/chess_clock_ctrl.sv
// Turn sequencer for a two-player chess clock: per-player countdown, Fischer
// increment on hand-over, pause/resume, reload and sticky flag-fall.
module chess_clock_ctrl #(
    parameter int TIME_W    = 13,
    parameter int INIT_TIME = 300,
    parameter int INCREMENT = 0,
    parameter int MAX_TIME  = 5999
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              TICK,
    input  logic              START,
    input  logic              BTN_A,
    input  logic              BTN_B,
    input  logic              PAUSE,
    input  logic              LOAD,
    output logic              PS_CE,
    output logic              PS_CLR,
    output logic [TIME_W-1:0] TIME_A,
    output logic [TIME_W-1:0] TIME_B,
    output logic [1:0]        ACTIVE,
    output logic [1:0]        FLAG
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_A   = 3'd1,
        RUN_B   = 3'd2,
        PAUSE_A = 3'd3,
        PAUSE_B = 3'd4,
        OVER    = 3'd5
    } state_t;

    localparam logic [TIME_W-1:0] INIT_V  = TIME_W'(INIT_TIME);
    localparam logic [TIME_W:0]   INC_V   = (TIME_W+1)'(INCREMENT);
    localparam logic [TIME_W:0]   MAX_V   = (TIME_W+1)'(MAX_TIME);

    state_t            state_reg;
    logic [TIME_W-1:0] dec_a;
    logic [TIME_W-1:0] dec_b;
    logic              fall_a;
    logic              fall_b;
    logic              running;

    // One extra bit so the increment cannot wrap before it is clamped.
    function automatic logic [TIME_W-1:0] add_inc(input logic [TIME_W-1:0] t);
        logic [TIME_W:0] s;
        s = {1'b0, t} + INC_V;
        if (s > MAX_V)
            s = MAX_V;
        return s[TIME_W-1:0];
    endfunction

    assign dec_a   = TICK ? TIME_A - 1'b1 : TIME_A;
    assign dec_b   = TICK ? TIME_B - 1'b1 : TIME_B;
    // Treating <=1 as a fall also guards against any underflow below zero.
    assign fall_a  = TICK && (TIME_A <= TIME_W'(1));
    assign fall_b  = TICK && (TIME_B <= TIME_W'(1));
    assign running = (state_reg == RUN_A) || (state_reg == RUN_B);

    assign PS_CE  = running;
    assign ACTIVE = (state_reg == RUN_A || state_reg == PAUSE_A) ? 2'b01 :
                    (state_reg == RUN_B || state_reg == PAUSE_B) ? 2'b10 : 2'b00;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_reg <= IDLE;
            TIME_A    <= INIT_V;
            TIME_B    <= INIT_V;
            PS_CLR    <= 1'b0;
            FLAG      <= 2'b00;
        end else begin
            PS_CLR <= 1'b0;
            if (LOAD && !running) begin
                state_reg <= IDLE;
                TIME_A    <= INIT_V;
                TIME_B    <= INIT_V;
                FLAG      <= 2'b00;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (START) begin
                            state_reg <= RUN_A;
                            PS_CLR    <= 1'b1;
                        end
                    end
                    RUN_A: begin
                        if (fall_a) begin
                            TIME_A    <= '0;
                            FLAG[0]   <= 1'b1;
                            state_reg <= OVER;
                        end else if (PAUSE) begin
                            TIME_A    <= dec_a;
                            state_reg <= PAUSE_A;
                        end else if (BTN_A) begin
                            TIME_A    <= add_inc(dec_a);
                            state_reg <= RUN_B;
                            PS_CLR    <= 1'b1;
                        end else begin
                            TIME_A <= dec_a;
                        end
                    end
                    RUN_B: begin
                        if (fall_b) begin
                            TIME_B    <= '0;
                            FLAG[1]   <= 1'b1;
                            state_reg <= OVER;
                        end else if (PAUSE) begin
                            TIME_B    <= dec_b;
                            state_reg <= PAUSE_B;
                        end else if (BTN_B) begin
                            TIME_B    <= add_inc(dec_b);
                            state_reg <= RUN_A;
                            PS_CLR    <= 1'b1;
                        end else begin
                            TIME_B <= dec_b;
                        end
                    end
                    // Resume keeps the prescaler phase, so no PS_CLR here.
                    PAUSE_A: if (PAUSE) state_reg <= RUN_A;
                    PAUSE_B: if (PAUSE) state_reg <= RUN_B;
                    OVER:    ;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Scoreboard bench for chess_clock_ctrl with INIT_TIME=3, INCREMENT=2.
module tb_chess_clock_ctrl;

    localparam int TW = 13;

    logic          CLK = 1'b0;
    logic          CLR = 1'b0;
    logic          TICK = 1'b0, START = 1'b0, BTN_A = 1'b0, BTN_B = 1'b0;
    logic          PAUSE = 1'b0, LOAD = 1'b0;
    logic          PS_CE, PS_CLR;
    logic [TW-1:0] TIME_A, TIME_B;
    logic [1:0]    ACTIVE, FLAG;

    typedef struct {
        string         name;
        logic          ce;
        logic          clr;
        logic [TW-1:0] ta;
        logic [TW-1:0] tb;
        logic [1:0]    act;
        logic [1:0]    flg;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    chess_clock_ctrl #(.TIME_W(TW), .INIT_TIME(3), .INCREMENT(2), .MAX_TIME(5999)) dut (
        .CLK(CLK), .CLR(CLR), .TICK(TICK), .START(START), .BTN_A(BTN_A),
        .BTN_B(BTN_B), .PAUSE(PAUSE), .LOAD(LOAD), .PS_CE(PS_CE),
        .PS_CLR(PS_CLR), .TIME_A(TIME_A), .TIME_B(TIME_B),
        .ACTIVE(ACTIVE), .FLAG(FLAG)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs are all registered/state-decoded, so checking on the
    // falling edge sees the settled post-edge values.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (PS_CE !== e.ce || PS_CLR !== e.clr || TIME_A !== e.ta ||
                TIME_B !== e.tb || ACTIVE !== e.act || FLAG !== e.flg) begin
                errors++;
                $display("FAIL %s: got ce=%b clr=%b a=%0d b=%0d act=%b flag=%b, expected ce=%b clr=%b a=%0d b=%0d act=%b flag=%b",
                         e.name, PS_CE, PS_CLR, TIME_A, TIME_B, ACTIVE, FLAG,
                         e.ce, e.clr, e.ta, e.tb, e.act, e.flg);
            end else begin
                $display("[TB] ok %s: a=%0d b=%0d act=%b flag=%b ce=%b clr=%b",
                         e.name, TIME_A, TIME_B, ACTIVE, FLAG, PS_CE, PS_CLR);
            end
        end
    end

    task automatic push(input string name, input logic ce, input logic clr,
                        input int ta, input int tb, input logic [1:0] act,
                        input logic [1:0] flg);
        exp_t e;
        e.name = name; e.ce = ce; e.clr = clr;
        e.ta = TW'(ta); e.tb = TW'(tb); e.act = act; e.flg = flg;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of pulses {tick,start,btn_a,btn_b,pause,load}, then queue expectation.
    task automatic step(input string name, input logic [5:0] in,
                        input logic ce, input logic clr, input int ta, input int tb,
                        input logic [1:0] act, input logic [1:0] flg);
        @(negedge CLK);
        {TICK, START, BTN_A, BTN_B, PAUSE, LOAD} = in;
        @(posedge CLK);
        #1;
        {TICK, START, BTN_A, BTN_B, PAUSE, LOAD} = 6'b0;
        push(name, ce, clr, ta, tb, act, flg);
    endtask

    localparam logic [5:0] NONE = 6'b000000, TK = 6'b100000, ST = 6'b010000,
                           BA = 6'b001000, BB = 6'b000100, PA = 6'b000010,
                           LD = 6'b000001;

    initial begin
        // 1. reset and start
        CLR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        push("reset", 0, 0, 3, 3, 2'b00, 2'b00);
        @(negedge CLK);
        CLR = 1'b0;
        step("idle_tick_ignored", TK,      0, 0, 3, 3, 2'b00, 2'b00);
        step("start",             ST,      1, 1, 3, 3, 2'b01, 2'b00);
        step("start_psclr_drop",  NONE,    1, 0, 3, 3, 2'b01, 2'b00);
        // 2. countdown and hand-over
        step("runa_tick",         TK,      1, 0, 2, 3, 2'b01, 2'b00);
        step("runa_btnb_ignored", BB,      1, 0, 2, 3, 2'b01, 2'b00);
        step("runa_btna_handover",BA,      1, 1, 4, 3, 2'b10, 2'b00);
        step("handover_psclr_drop",NONE,   1, 0, 4, 3, 2'b10, 2'b00);
        // 3. pause, ignored inputs while paused, resume
        step("runb_pause",        PA,      0, 0, 4, 3, 2'b10, 2'b00);
        for (int i = 0; i < 5; i++)
            step("paused_tick",   TK,      0, 0, 4, 3, 2'b10, 2'b00);
        step("paused_btnb",       BB,      0, 0, 4, 3, 2'b10, 2'b00);
        step("paused_start",      ST,      0, 0, 4, 3, 2'b10, 2'b00);
        step("resume_no_psclr",   PA,      1, 0, 4, 3, 2'b10, 2'b00);
        // 4. flag fall for B, frozen OVER, reload
        step("runb_tick_2",       TK,      1, 0, 4, 2, 2'b10, 2'b00);
        step("runb_tick_1",       TK,      1, 0, 4, 1, 2'b10, 2'b00);
        step("runb_flag",         TK,      0, 0, 4, 0, 2'b00, 2'b10);
        step("over_tick",         TK,      0, 0, 4, 0, 2'b00, 2'b10);
        step("over_btnb",         BB,      0, 0, 4, 0, 2'b00, 2'b10);
        step("over_start",        ST,      0, 0, 4, 0, 2'b00, 2'b10);
        step("over_load",         LD,      0, 0, 3, 3, 2'b00, 2'b00);
        // 5. simultaneous tick + button
        step("start2",            ST,      1, 1, 3, 3, 2'b01, 2'b00);
        step("a_tick_2",          TK,      1, 0, 2, 3, 2'b01, 2'b00);
        step("a_tick_1",          TK,      1, 0, 1, 3, 2'b01, 2'b00);
        step("tick_btn_flag_wins",TK | BA, 0, 0, 0, 3, 2'b00, 2'b01);
        step("load_after_flag_a", LD,      0, 0, 3, 3, 2'b00, 2'b00);
        step("start3",            ST,      1, 1, 3, 3, 2'b01, 2'b00);
        step("a_tick",            TK,      1, 0, 2, 3, 2'b01, 2'b00);
        step("tick_btn_inc",      TK | BA, 1, 1, 3, 3, 2'b10, 2'b00);
        step("tick_pause",        TK | PA, 0, 0, 3, 2, 2'b10, 2'b00);
        step("tick_load_paused",  TK | LD, 0, 0, 3, 3, 2'b00, 2'b00);
        // 6. load ignored while running, async clear mid-game
        step("start4",            ST,      1, 1, 3, 3, 2'b01, 2'b00);
        step("run_tick",          TK,      1, 0, 2, 3, 2'b01, 2'b00);
        step("run_load_ignored",  LD,      1, 0, 2, 3, 2'b01, 2'b00);
        step("run_load_tick",     LD | TK, 1, 0, 1, 3, 2'b01, 2'b00);
        @(posedge CLK);
        #2;
        CLR = 1'b1;
        #1;
        push("async_clr", 0, 0, 3, 3, 2'b00, 2'b00);
        @(negedge CLK);
        #1;
        CLR = 1'b0;
        step("start_after_clr",   ST,      1, 1, 3, 3, 2'b01, 2'b00);

        repeat (3) @(negedge CLK);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
